// File: rtl/gtx_rx_checker.sv
// GTX RX test-pattern checker: K28.5 comma alignment, one-byte realignment, lock tracking, error counting.
// Optional BER word counter enabled by defining GTX_RX_CHK_WCNT_EN.
module gtx_rx_checker #(
    parameter int PERIOD    = 16,
    parameter int LOCK_GOOD = 4,
    parameter int LOSS_BAD  = 2,
    parameter int ERR_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [15:0]      data_i,
    input  logic [1:0]       ctrl_i,
    input  logic             clr_i,
    output logic [15:0]      data_o,
    output logic [1:0]       ctrl_o,
    output logic             aligned_o,
    output logic             locked_o,
    output logic             swap_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [31:0]      wcnt_o
);
    localparam int          GW       = $clog2(LOCK_GOOD + 1);
    localparam int          BW       = $clog2(LOSS_BAD + 1);
    localparam logic [7:0]  EXP_LAST = 8'(PERIOD - 1);
    localparam logic [15:0] COMMA    = 16'hBCBC;

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t           state_q, state_d;
    logic             swap_q, swap_d;
    logic [7:0]       exp_q, exp_d;
    logic [GW-1:0]    good_q, good_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [15:0]      data_q;
    logic [1:0]       ctrl_q;
    // Only the upper byte of the previous word is ever spliced into a realigned word.
    logic [7:0]       prev_hi_q;
    logic             prev_khi_q;

    logic [15:0] word;
    logic [1:0]  kflag;
    logic [15:0] exp_word;
    logic [1:0]  exp_kflag;
    logic        match;
    logic [7:0]  exp_next;

    always_comb begin
        word      = swap_q ? {data_i[7:0], prev_hi_q} : data_i;
        kflag     = swap_q ? {ctrl_i[0], prev_khi_q} : ctrl_i;
        exp_word  = (exp_q == '0) ? COMMA : {exp_q, exp_q};
        exp_kflag = (exp_q == '0) ? 2'b11 : 2'b00;
        match     = (word == exp_word) && (kflag == exp_kflag);
        exp_next  = (exp_q == EXP_LAST) ? 8'd0 : exp_q + 8'd1;
    end

    always_comb begin
        state_d   = state_q;
        swap_d    = swap_q;
        exp_d     = exp_q;
        good_d    = good_q;
        bad_d     = bad_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        case (state_q)
            HUNT: begin
                if (ctrl_i == 2'b11 && data_i == COMMA) begin
                    swap_d  = 1'b0;
                    exp_d   = 8'd1;
                    state_d = SYNC;
                end else if (ctrl_i == 2'b10 && data_i[15:8] == 8'hBC) begin
                    // Comma straddles two words; the realigned comma is checked next cycle.
                    swap_d  = 1'b1;
                    exp_d   = 8'd0;
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (match) begin
                    exp_d = exp_next;
                    if (exp_q == EXP_LAST) begin
                        if (good_q == GW'(LOCK_GOOD - 1)) begin
                            state_d = LOCKED;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end
                end else begin
                    state_d = HUNT;
                    good_d  = '0;
                    exp_d   = 8'd0;
                end
            end
            LOCKED: begin
                exp_d = exp_next;
                if (!match) begin
                    err_d = 1'b1;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                end
                if (exp_q == '0) begin
                    if (match) begin
                        bad_d = '0;
                    end else if (bad_q == BW'(LOSS_BAD - 1)) begin
                        state_d = HUNT;
                        bad_d   = '0;
                        exp_d   = 8'd0;
                    end else begin
                        bad_d = bad_q + BW'(1);
                    end
                end
            end
            default: state_d = HUNT;
        endcase
        if (clr_i) err_cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= HUNT;
            swap_q     <= 1'b0;
            exp_q      <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            data_q     <= '0;
            ctrl_q     <= '0;
            prev_hi_q  <= '0;
            prev_khi_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            swap_q     <= swap_d;
            exp_q      <= exp_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            data_q     <= word;
            ctrl_q     <= kflag;
            prev_hi_q  <= data_i[15:8];
            prev_khi_q <= ctrl_i[1];
        end
    end

`ifdef GTX_RX_CHK_WCNT_EN
    logic [31:0] wcnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wcnt_q <= '0;
        end else if (clr_i) begin
            wcnt_q <= '0;
        end else if (state_q == LOCKED && wcnt_q != 32'hFFFF_FFFF) begin
            wcnt_q <= wcnt_q + 32'd1;
        end
    end

    assign wcnt_o = wcnt_q;
`else
    assign wcnt_o = '0;
`endif

    assign data_o    = data_q;
    assign ctrl_o    = ctrl_q;
    assign aligned_o = (state_q != HUNT);
    assign locked_o  = (state_q == LOCKED);
    assign swap_o    = swap_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_gtx_rx_checker.sv
// Scoreboard bench for gtx_rx_checker: aligned and byte-shifted streams, error injection,
// loss of lock and relock, clear-vs-error priority and asynchronous reset.
`timescale 1ns/1ps
module tb_gtx_rx_checker;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [15:0] data_i;
    logic [1:0]  ctrl_i;
    logic        clr_i;
    logic [15:0] data_o;
    logic [1:0]  ctrl_o;
    logic        aligned_o;
    logic        locked_o;
    logic        swap_o;
    logic        err_o;
    logic [31:0] err_cnt_o;
    logic [31:0] wcnt_o;

    gtx_rx_checker dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .data_i    (data_i),
        .ctrl_i    (ctrl_i),
        .clr_i     (clr_i),
        .data_o    (data_o),
        .ctrl_o    (ctrl_o),
        .aligned_o (aligned_o),
        .locked_o  (locked_o),
        .swap_o    (swap_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o),
        .wcnt_o    (wcnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        chk;
        logic [15:0] d;
        logic [1:0]  c;
    } exp_t;

    exp_t        dataQ[$];
    logic [31:0] errQ[$];
    exp_t        monE;
    int          compared   = 0;
    int          mismatched = 0;
    bit          swapMode;
    logic [15:0] lastD;
    logic [1:0]  lastC;
    logic [31:0] expErrCnt;
    logic [31:0] expWcnt;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, required);
        end
    endtask

    function automatic logic [15:0] patD(input int idx);
        return (idx == 0) ? 16'hBCBC : {idx[7:0], idx[7:0]};
    endfunction

    function automatic logic [1:0] patC(input int idx);
        return (idx == 0) ? 2'b11 : 2'b00;
    endfunction

    // Drives one logical word (byte-shifted on the wire in swapMode) and queues the expected responses.
    task automatic applyStimulus(input logic [15:0] d, input logic [1:0] c, input bit isErr, input bit clr, input bit chk);
        exp_t e;
        @(negedge clk_i);
        if (swapMode) begin
            data_i = {d[7:0], lastD[15:8]};
            ctrl_i = {c[0], lastC[1]};
            e.d    = lastD;
            e.c    = lastC;
        end else begin
            data_i = d;
            ctrl_i = c;
            e.d    = d;
            e.c    = c;
        end
        e.chk = chk;
        clr_i = clr;
        dataQ.push_back(e);
        if (isErr) begin
            expErrCnt = clr ? 32'd0 : expErrCnt + 32'd1;
            errQ.push_back(expErrCnt);
        end else if (clr) begin
            expErrCnt = 32'd0;
        end
        lastD = d;
        lastC = c;
        @(posedge clk_i);
        #1;
        clr_i = 1'b0;
    endtask

    always @(posedge clk_i) begin
        #1;
        if (dataQ.size() > 0) begin
            monE = dataQ.pop_front();
            if (monE.chk) begin
                checkOutput("data_o", {16'd0, data_o}, {16'd0, monE.d});
                checkOutput("ctrl_o", {30'd0, ctrl_o}, {30'd0, monE.c});
            end
        end
        if (err_o === 1'b1) begin
            if (errQ.size() == 0) checkOutput("err_o_unexpected", {31'd0, err_o}, 32'd0);
            else                  checkOutput("err_cnt_at_pulse", err_cnt_o, errQ.pop_front());
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data_o"}, {16'd0, data_o}, 32'd0);
        checkOutput({tag, "_ctrl_o"}, {30'd0, ctrl_o}, 32'd0);
        checkOutput({tag, "_aligned_o"}, {31'd0, aligned_o}, 32'd0);
        checkOutput({tag, "_locked_o"}, {31'd0, locked_o}, 32'd0);
        checkOutput({tag, "_swap_o"}, {31'd0, swap_o}, 32'd0);
        checkOutput({tag, "_err_o"}, {31'd0, err_o}, 32'd0);
        checkOutput({tag, "_err_cnt_o"}, err_cnt_o, 32'd0);
        checkOutput({tag, "_wcnt_o"}, wcnt_o, 32'd0);
    endtask

    initial begin
        int base;
        rst_n_i   = 1'b0;
        data_i    = '0;
        ctrl_i    = '0;
        clr_i     = 1'b0;
        swapMode  = 1'b0;
        lastD     = '0;
        lastC     = '0;
        expErrCnt = '0;
        #12;
        checkAllZero("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < 3; i++) applyStimulus(16'h0000, 2'b00, 0, 0, 1);
        checkOutput("idle_aligned_o", {31'd0, aligned_o}, 32'd0);

        // Aligned stream: comma captured on the first edge, lock after the 64th word.
        for (int t = 0; t < 80; t++) begin
            applyStimulus(patD(t % 16), patC(t % 16), 0, 0, 1);
            if (t == 0) begin
                checkOutput("al_aligned_o_t0", {31'd0, aligned_o}, 32'd1);
                checkOutput("al_swap_o_t0", {31'd0, swap_o}, 32'd0);
                checkOutput("al_locked_o_t0", {31'd0, locked_o}, 32'd0);
            end
            if (t == 62) checkOutput("al_locked_o_t62", {31'd0, locked_o}, 32'd0);
            if (t == 63) checkOutput("al_locked_o_t63", {31'd0, locked_o}, 32'd1);
        end
        checkOutput("al_err_cnt_o", err_cnt_o, 32'd0);
`ifdef GTX_RX_CHK_WCNT_EN
        expWcnt = 32'd16;
`else
        expWcnt = 32'd0;
`endif
        checkOutput("al_wcnt_o", wcnt_o, expWcnt);

        // Single corrupted word 0x0505 -> 0x0504.
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                applyStimulus(16'h0504, 2'b00, 1, 0, 1);
                checkOutput("one_err_o", {31'd0, err_o}, 32'd1);
                checkOutput("one_err_cnt_o", err_cnt_o, 32'd1);
                checkOutput("one_locked_o", {31'd0, locked_o}, 32'd1);
            end else begin
                applyStimulus(patD(i), patC(i), 0, 0, 1);
                if (i == 6) checkOutput("one_err_o_after", {31'd0, err_o}, 32'd0);
            end
        end
        checkOutput("one_locked_o_end", {31'd0, locked_o}, 32'd1);
`ifdef GTX_RX_CHK_WCNT_EN
        expWcnt = 32'd32;
`else
        expWcnt = 32'd0;
`endif
        checkOutput("one_wcnt_o", wcnt_o, expWcnt);

        // Clear without an error.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(patD(i), patC(i), 0, (i == 2), 1);
            if (i == 2) begin
                checkOutput("clr_err_cnt_o", err_cnt_o, 32'd0);
                checkOutput("clr_wcnt_o", wcnt_o, 32'd0);
            end
        end

        // Two consecutive bad commas drop lock.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                if (i == 0) begin
                    applyStimulus(16'h0000, 2'b00, 1, 0, 1);
                    if (f == 0) begin
                        checkOutput("loss1_locked_o", {31'd0, locked_o}, 32'd1);
                        checkOutput("loss1_err_cnt_o", err_cnt_o, 32'd1);
                    end else begin
                        checkOutput("loss2_locked_o", {31'd0, locked_o}, 32'd0);
                        checkOutput("loss2_aligned_o", {31'd0, aligned_o}, 32'd0);
                        checkOutput("loss2_err_cnt_o", err_cnt_o, 32'd2);
                    end
                end else begin
                    applyStimulus(patD(i), patC(i), 0, 0, 1);
                end
            end
        end
        checkOutput("hunt_aligned_o", {31'd0, aligned_o}, 32'd0);

        // Relock from the next valid comma.
        for (int r = 0; r < 64; r++) begin
            applyStimulus(patD(r % 16), patC(r % 16), 0, 0, 1);
            if (r == 0)  checkOutput("relock_aligned_o_r0", {31'd0, aligned_o}, 32'd1);
            if (r == 62) checkOutput("relock_locked_o_r62", {31'd0, locked_o}, 32'd0);
            if (r == 63) checkOutput("relock_locked_o_r63", {31'd0, locked_o}, 32'd1);
        end

        // Five errors bring the count to 7, then clear collides with an error.
        for (int i = 0; i < 16; i++) begin
            base = i;
            if (i >= 3 && i <= 7) begin
                applyStimulus(patD(base) ^ 16'h0100, 2'b00, 1, 0, 1);
                if (i == 7) checkOutput("err7_err_cnt_o", err_cnt_o, 32'd7);
            end else if (i == 9) begin
                applyStimulus(patD(base) ^ 16'h0100, 2'b00, 1, 1, 1);
                checkOutput("clrerr_err_o", {31'd0, err_o}, 32'd1);
                checkOutput("clrerr_err_cnt_o", err_cnt_o, 32'd0);
            end else begin
                applyStimulus(patD(base), patC(base), 0, 0, 1);
            end
        end
        checkOutput("clrerr_locked_o", {31'd0, locked_o}, 32'd1);

        // Asynchronous reset mid-cycle while locked.
        #2;
        rst_n_i = 1'b0;
        #1;
        checkAllZero("async_rst");
        checkOutput("errq_drained_rst", errQ.size(), 32'd0);
        dataQ.delete();
        errQ.delete();
        expErrCnt = '0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        lastD   = '0;
        lastC   = '0;
        for (int i = 0; i < 2; i++) applyStimulus(16'h0000, 2'b00, 0, 0, 1);
        checkOutput("post_rst_aligned_o", {31'd0, aligned_o}, 32'd0);
        checkOutput("post_rst_locked_o", {31'd0, locked_o}, 32'd0);

        // Stream shifted by one byte: realignment engages, lock one word later.
        swapMode = 1'b1;
        for (int t = 0; t < 70; t++) begin
            applyStimulus(patD(t % 16), patC(t % 16), 0, 0, (t != 0));
            if (t == 0) begin
                checkOutput("sw_swap_o_t0", {31'd0, swap_o}, 32'd1);
                checkOutput("sw_aligned_o_t0", {31'd0, aligned_o}, 32'd1);
            end
            if (t == 1) begin
                checkOutput("sw_data_o_t1", {16'd0, data_o}, 32'h0000BCBC);
                checkOutput("sw_ctrl_o_t1", {30'd0, ctrl_o}, 32'd3);
            end
            if (t == 2) begin
                checkOutput("sw_data_o_t2", {16'd0, data_o}, 32'h00000101);
                checkOutput("sw_ctrl_o_t2", {30'd0, ctrl_o}, 32'd0);
            end
            if (t == 63) checkOutput("sw_locked_o_t63", {31'd0, locked_o}, 32'd0);
            if (t == 64) checkOutput("sw_locked_o_t64", {31'd0, locked_o}, 32'd1);
        end
        checkOutput("sw_swap_o_end", {31'd0, swap_o}, 32'd1);
        checkOutput("sw_err_cnt_o", err_cnt_o, 32'd0);

        @(negedge clk_i);
        checkOutput("errq_drained_end", errQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gtx_rx_checker.md
Name: gtx_rx_checker

Overview:
- Receive-side consumer of the GTX test stream: takes 16-bit RX data plus 2-bit K-character flags from the transceiver.
- Finds the K28.5 comma word and corrects a one-byte misalignment.
- Checks every word against the expected 16-word test pattern and reports alignment, lock and error statistics.
- Sits directly after the GTX RX interface; drives link-status LEDs/registers and the BER monitor.

Parameters:
- PERIOD, 16, words per pattern frame (comma + PERIOD-1 counting words); range 2..256
- LOCK_GOOD, 4, consecutive error-free frames in SYNC required to declare lock
- LOSS_BAD, 2, consecutive bad comma words in LOCKED that drop lock
- ERR_W, 32, width of the error counter

Ports:
- clk_i  in  1  RX user clock
- rst_n_i  in  1  reset, asynchronous, active-low
- data_i  in  16  RX data; bits [7:0] are the first byte on the wire
- ctrl_i  in  2  RX K flags; bit n set = byte n is a K character
- clr_i  in  1  synchronous clear of err_cnt_o (and word counter when enabled)
- data_o  out  16  byte-realigned data, 1-cycle latency
- ctrl_o  out  2  byte-realigned K flags, 1-cycle latency
- aligned_o  out  1  state is SYNC or LOCKED
- locked_o  out  1  state is LOCKED
- swap_o  out  1  1 = byte realignment active
- err_o  out  1  1-cycle pulse per mismatched word while LOCKED
- err_cnt_o  out  ERR_W  saturating count of err_o pulses
- wcnt_o  out  32  words checked while LOCKED (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state HUNT, swap=0, expected index exp=0, good/bad counters 0; prev_data/prev_ctrl registers 0.
- Every cycle, register prev_data<=data_i and prev_ctrl<=ctrl_i.
- Aligned word w (combinational):
  - swap=0: w=data_i, k=ctrl_i.
  - swap=1: w={data_i[7:0],prev_data[15:8]}, k={ctrl_i[0],prev_ctrl[1]}.
- data_o<=w and ctrl_o<=k every cycle in all states.
- Expected word:
  - exp==0: k=2'b11, w=16'hBCBC.
  - otherwise: k=2'b00, w={exp[7:0],exp[7:0]}.
- exp wraps from PERIOD-1 to 0.
- HUNT:
  - Comma detection uses the raw input, not w.
  - ctrl_i==2'b11 and data_i==16'hBCBC -> swap<=0, exp<=1, go SYNC.
  - Else ctrl_i==2'b10 and data_i[15:8]==8'hBC -> swap<=1, exp<=0, go SYNC; the realigned comma appears on the next cycle.
  - Anything else: stay in HUNT.
- SYNC:
  - w/k matches expected -> exp advances.
  - Match at exp==PERIOD-1 -> good_cnt++; reaching LOCK_GOOD -> go LOCKED, good_cnt<=0, bad_cnt<=0.
  - Any mismatch -> HUNT, good_cnt<=0.
  - Mismatches in SYNC/HUNT do not pulse err_o or touch err_cnt_o.
- LOCKED:
  - exp advances every cycle regardless of match.
  - Mismatch -> err_o=1 next cycle, err_cnt_o++ (saturates at all-ones, never wraps).
  - Mismatch at exp==0 -> bad_cnt++; a correct comma clears bad_cnt.
  - bad_cnt reaching LOSS_BAD -> go HUNT, locked_o/aligned_o drop next cycle.
  - swap is held while LOCKED.
- clr_i has priority over increment: clr_i with a simultaneous error leaves err_cnt_o=0, but err_o still pulses.
- Lock latency, aligned stream, LOCK_GOOD=4, PERIOD=16: comma captured at edge 0 -> locked_o high after edge 63. Swapped stream: edge 64.
- Reset mid-operation returns everything to the reset values immediately (async).

Optional Feature:
- Macro GTX_RX_CHK_WCNT_EN.
- Defined: wcnt_o increments (saturating at 32'hFFFFFFFF) on every cycle spent in LOCKED, and clears on clr_i (clr wins). err_cnt_o/wcnt_o then gives BER.
- Not defined: wcnt_o is tied to 0 and no counter logic is built.

Test Plan:
- Ideal stream (ctrl 11/BCBC, then {k,k} for k=1..15, repeating) -> swap_o=0; aligned_o after edge 0; locked_o after edge 63; data_o equals input delayed 1 cycle; err_cnt_o=0.
- Same stream delayed by one byte -> swap_o=1; data_o shows 16'hBCBC with ctrl_o=2'b11 then 16'h0101; locked_o after edge 64.
- Locked; word 16'h0505 corrupted to 16'h0504 once -> err_o one pulse, err_cnt_o=1, locked_o stays 1; wcnt_o keeps counting when GTX_RX_CHK_WCNT_EN is defined.
- Locked; two consecutive comma words replaced by 16'h0000/ctrl 00 -> err_cnt_o=2, locked_o=0 and aligned_o=0 after the second; relock 64 cycles after the next valid comma.
- err_cnt_o=7, clr_i asserted on the same cycle as an error -> err_cnt_o=0, err_o=1.
- rst_n_i pulsed low while locked -> all outputs 0 immediately; state HUNT on release.
